nibble_demux_1x8: RTL and testbench
===================================

# nibble_demux_1x8

Registered 1-to-8 nibble demultiplexer: the write side of the 8-to-1 digit-select path. It accepts a stream of 4-bit values over a valid/ready handshake, distributes them into eight output slots `x0`..`x7` by an internal write pointer, and signals frame completion. It sits between the value-producing logic (BCD/counter logic) and the digit-select mux that scans the slots onto the display.

## Interface
- `WIDTH`, 4: bits per slot.
- `DEPTH`, 8: number of slots. Fixed; the pointer is 3 bits.
- `clk` input 1: single clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: input beat present.
- `in_ready` output 1: block can accept a beat.
- `in_data` input WIDTH: nibble to store.
- `in_sof` input 1: start of frame, qualified by `in_valid`. Forces the beat into slot 0.
- `hold` input 1: defers the commit of a completed frame (double-buffer build only).
- `x0`..`x7` output WIDTH each: slot contents, registered.
- `wr_ptr` output 3: slot the next beat is written to.
- `frame_done` output 1: one-cycle pulse when a frame is committed.
- `frame_abort` output 1: one-cycle pulse when `in_sof` restarts a partial frame.

## Operation
- A beat is accepted when `in_valid && in_ready` is true at a rising `clk`.
- Slot selection:
  - Accepted beat without `in_sof`: written to slot `wr_ptr`, then `wr_ptr` increments modulo 8 (7 wraps to 0).
  - Accepted beat with `in_sof`: written to slot 0 and `wr_ptr` becomes 1.
  - If `wr_ptr != 0` when an sof beat is accepted, the partial frame is discarded and `frame_abort` pulses.
- A frame completes when a beat is written to slot 7.
- State machine (double-buffer build):
  - FILL: `in_ready`=1. Accepted beats write the shadow bank.
    - Slot-7 write with `hold`=0: commit shadow to `x0`..`x7` at that same edge, including the slot-7 value. Stay in FILL.
    - Slot-7 write with `hold`=1: go to PEND.
  - PEND: `in_ready`=0 and input is ignored, `in_sof` included. Contents are frozen. When `hold` is sampled 0, commit, pulse `frame_done`, and return to FILL.
- `hold` has no effect outside a frame completion or PEND.
- Reset (asserted at any time, mid-frame or in PEND):
  - `x0`..`x7` = 0, shadow = 0, `wr_ptr` = 0.
  - State = FILL, so `in_ready` = 1 once reset is released.
  - `frame_done` = 0, `frame_abort` = 0.
- `in_data` is stored as-is; there is no arithmetic.

## Timing
- `frame_done` and `frame_abort` are registered. Each is high for exactly the one cycle after the triggering edge, together with the updated outputs.
- Write latency:
  - Direct-write build: a slot is visible one cycle after acceptance.
  - Double-buffer build: all eight slots change together one cycle after the committing edge.
- `in_ready` is a decode of state and is combinational from registers only, never from `in_valid`.
- In PEND, `in_ready` rises in the cycle after the edge where `hold`=0 was sampled.
- Back-to-back frames at one beat per cycle are sustained when `hold`=0: no bubble after slot 7.

## Configuration
- `NIBBLE_DEMUX_DOUBLE_BUFFER_EN` defined:
  - Shadow bank plus FILL/PEND behaviour as above.
  - Outputs never show a partial frame.
- Not defined:
  - No shadow bank; each beat writes `x[wr_ptr]` directly.
  - `hold` is ignored and `in_ready` is constant 1. PEND does not exist.
  - `frame_done` still pulses one cycle after each slot-7 write.
  - `frame_abort` still pulses on an sof restart; slots written before the restart keep their values.

## Structure
- Package `nibble_demux_pkg`: `WIDTH`, `DEPTH`, pointer width, and the FILL/PEND state enum.
- Sub-module `nibble_bank`: an 8×WIDTH register file with one write port (enable, 3-bit address, data), parallel outputs, and reset to 0.
  - Used once in the direct-write build.
  - Used twice in the double-buffer build: shadow bank plus an output bank with a parallel-load input.

## Test plan
- Reset release, then 8 beats 1..8 with sof on the first, `hold`=0: `x0..x7` = 1..8, `frame_done` pulses once, `wr_ptr` = 0.
- Double-buffer build, after 4 beats of a new frame 9,A,B,C: `x0..x7` still show 1..8; after beat 8, all slots update in one cycle.
- Slot-7 beat with `hold`=1 for 5 cycles: `in_ready`=0 and extra `in_valid` beats are ignored. `hold`=0 gives commit, a `frame_done` pulse, and `in_ready`=1 the next cycle.
- 3 beats, then an sof beat 0xF: `frame_abort` pulses, `x0` shadow = F, `wr_ptr` = 1; the aborted values never reach the outputs.
- `reset_n` pulsed low mid-frame and while in PEND: all outputs 0 immediately (asynchronous), `in_ready` = 1 after release.
- Direct-write build, beat 0x5 at `wr_ptr` 2: `x2` = 5 one cycle later; `hold`=1 has no effect.

Source files
------------

// File: rtl/nibble_demux_pkg.sv
// Shared sizing and state encoding for the nibble demux write path.
package nibble_demux_pkg;
  localparam int WIDTH = 4;
  localparam int DEPTH = 8;
  localparam int PTR_W = 3;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_PEND = 1'b1
  } state_t;
endpackage

// File: rtl/nibble_demux_1x8_bank.sv
// 8 x WIDTH register file: one write port plus a parallel load, reset to 0.
// Registered, one-cycle write latency; parallel load takes priority over the write port.
module nibble_bank
  import nibble_demux_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         i_we,
  input  logic [PTR_W-1:0]             i_addr,
  input  logic [WIDTH-1:0]             i_wdat,
  input  logic                         i_load,
  input  logic [DEPTH-1:0][WIDTH-1:0]  i_load_dat,
  output logic [DEPTH-1:0][WIDTH-1:0]  o_q
);
  logic [DEPTH-1:0][WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_load_dat;
    end else if (i_we) begin
      r_q[i_addr] <= i_wdat;
    end
  end

  assign o_q = r_q;
endmodule

// File: rtl/nibble_demux_1x8.sv
// 1-to-8 registered nibble demux; slots update one cycle after write/commit. NIBBLE_DEMUX_DOUBLE_BUFFER_EN
// adds a shadow bank and a PEND state (in_ready low) while hold defers a completed frame.
module nibble_demux_1x8
  import nibble_demux_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_sof,
  input  logic              hold,
  output logic [WIDTH-1:0]  x0,
  output logic [WIDTH-1:0]  x1,
  output logic [WIDTH-1:0]  x2,
  output logic [WIDTH-1:0]  x3,
  output logic [WIDTH-1:0]  x4,
  output logic [WIDTH-1:0]  x5,
  output logic [WIDTH-1:0]  x6,
  output logic [WIDTH-1:0]  x7,
  output logic [PTR_W-1:0]  wr_ptr,
  output logic              frame_done,
  output logic              frame_abort
);
  logic [PTR_W-1:0]            r_ptr;
  logic                        r_done;
  logic                        r_abort;
  logic                        w_acc;
  logic [PTR_W-1:0]            w_slot;
  logic                        w_last;
  logic                        w_done_set;
  logic [DEPTH-1:0][WIDTH-1:0] w_q;

  assign w_acc  = in_valid && in_ready;
  assign w_slot = in_sof ? '0 : r_ptr;
  assign w_last = w_acc && (w_slot == PTR_W'(DEPTH - 1));

`ifdef NIBBLE_DEMUX_DOUBLE_BUFFER_EN
  state_t                      r_state;
  logic                        w_commit;
  logic [DEPTH-1:0][WIDTH-1:0] w_shadow;
  logic [DEPTH-1:0][WIDTH-1:0] w_load_dat;

  assign in_ready   = (r_state == ST_FILL);
  assign w_commit   = !hold && (w_last || (r_state == ST_PEND));
  assign w_done_set = w_commit;

  // Committing on the slot-7 edge must include the beat being written right now.
  always_comb begin
    w_load_dat = w_shadow;
    if (w_last) begin
      w_load_dat[DEPTH-1] = in_data;
    end
  end

  nibble_bank u_shadow (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_we       (w_acc),
    .i_addr     (w_slot),
    .i_wdat     (in_data),
    .i_load     (1'b0),
    .i_load_dat ('0),
    .o_q        (w_shadow)
  );

  nibble_bank u_out (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_we       (1'b0),
    .i_addr     ('0),
    .i_wdat     ('0),
    .i_load     (w_commit),
    .i_load_dat (w_load_dat),
    .o_q        (w_q)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_FILL;
    end else begin
      case (r_state)
        ST_FILL: if (w_last && hold) r_state <= ST_PEND;
        ST_PEND: if (!hold)          r_state <= ST_FILL;
        default:                     r_state <= ST_FILL;
      endcase
    end
  end
`else
  logic w_unused_hold;

  assign w_unused_hold = hold;
  assign in_ready      = 1'b1;
  assign w_done_set    = w_last;

  nibble_bank u_out (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_we       (w_acc),
    .i_addr     (w_slot),
    .i_wdat     (in_data),
    .i_load     (1'b0),
    .i_load_dat ('0),
    .o_q        (w_q)
  );
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr   <= '0;
      r_done  <= 1'b0;
      r_abort <= 1'b0;
    end else begin
      if (w_acc) begin
        r_ptr <= in_sof ? PTR_W'(1) : r_ptr + PTR_W'(1);
      end
      r_done  <= w_done_set;
      r_abort <= w_acc && in_sof && (r_ptr != '0);
    end
  end

  assign x0          = w_q[0];
  assign x1          = w_q[1];
  assign x2          = w_q[2];
  assign x3          = w_q[3];
  assign x4          = w_q[4];
  assign x5          = w_q[5];
  assign x6          = w_q[6];
  assign x7          = w_q[7];
  assign wr_ptr      = r_ptr;
  assign frame_done  = r_done;
  assign frame_abort = r_abort;
endmodule

// File: tb/tb_nibble_demux_1x8.sv
// Scoreboard bench for nibble_demux_1x8; follows NIBBLE_DEMUX_DOUBLE_BUFFER_EN like the RTL.
module tb_nibble_demux_1x8;
  typedef struct packed {
    logic [7:0][3:0] x;
    logic [2:0]      ptr;
    logic            rdy;
    logic            done;
    logic            abort;
  } snap_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_sof = 1'b0;
  logic       hold = 1'b0;
  logic [3:0] in_data = 4'h0;
  logic       in_ready;
  logic [3:0] x0, x1, x2, x3, x4, x5, x6, x7;
  logic [2:0] wr_ptr;
  logic       frame_done, frame_abort;

  snap_t sb[$];
  snap_t exp_s, obs_s;
  int    total = 0;
  int    bad = 0;

  logic [7:0][3:0] m_x, m_sh;
  logic [2:0]      m_ptr;
  logic            m_pend, m_done, m_abort;

  nibble_demux_1x8 dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sof(in_sof), .hold(hold),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3), .x4(x4), .x5(x5), .x6(x6), .x7(x7),
    .wr_ptr(wr_ptr), .frame_done(frame_done), .frame_abort(frame_abort)
  );

  always #5 clk = ~clk;

  function automatic snap_t get_obs();
    snap_t s;
    s.x     = {x7, x6, x5, x4, x3, x2, x1, x0};
    s.ptr   = wr_ptr;
    s.rdy   = in_ready;
    s.done  = frame_done;
    s.abort = frame_abort;
    return s;
  endfunction

  function automatic snap_t model_snap();
    snap_t s;
    s.x     = m_x;
    s.ptr   = m_ptr;
    s.rdy   = !m_pend;
    s.done  = m_done;
    s.abort = m_abort;
    return s;
  endfunction

  task automatic model_reset();
    m_x = '0; m_sh = '0; m_ptr = '0;
    m_pend = 1'b0; m_done = 1'b0; m_abort = 1'b0;
    sb.push_back(model_snap());
  endtask

  // Drive one cycle, push the spec-derived expectation, advance to just after the edge.
  task automatic cycle(input logic v, input logic [3:0] d, input logic s, input logic h);
    logic [2:0] slot;
    logic       acc;
    in_valid = v; in_data = d; in_sof = s; hold = h;
    acc = v && !m_pend;
    slot = s ? 3'd0 : m_ptr;
    m_done = 1'b0;
    m_abort = 1'b0;
`ifdef NIBBLE_DEMUX_DOUBLE_BUFFER_EN
    if (m_pend) begin
      if (!h) begin
        m_x = m_sh; m_done = 1'b1; m_pend = 1'b0;
      end
    end else if (acc) begin
      m_abort = s && (m_ptr != 3'd0);
      m_sh[slot] = d;
      m_ptr = s ? 3'd1 : m_ptr + 3'd1;
      if (slot == 3'd7) begin
        if (h) m_pend = 1'b1;
        else begin
          m_x = m_sh; m_done = 1'b1;
        end
      end
    end
`else
    if (acc) begin
      m_abort = s && (m_ptr != 3'd0);
      m_x[slot] = d;
      m_ptr = s ? 3'd1 : m_ptr + 3'd1;
      m_done = (slot == 3'd7);
    end
`endif
    sb.push_back(model_snap());
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    #2 model_reset();
    exp_s = sb.pop_front(); obs_s = get_obs(); total++;
    if (obs_s !== exp_s) begin bad++; $display("FAIL reset_state got=%h want=%h", obs_s, exp_s); end
    @(negedge clk);
    reset_n = 1'b1;
    cycle(1'b0, 4'h0, 1'b0, 1'b0);
    exp_s = sb.pop_front(); obs_s = get_obs(); total++;
    if (obs_s !== exp_s) begin bad++; $display("FAIL reset_release got=%h want=%h", obs_s, exp_s); end
  endtask

  task automatic test_basic_frame();
    int dones = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 4'(i + 1), i == 0, 1'b0);
      exp_s = sb.pop_front(); obs_s = get_obs(); total++;
      if (obs_s !== exp_s) begin bad++; $display("FAIL basic beat%0d got=%h want=%h", i, obs_s, exp_s); end
      if (frame_done === 1'b1) dones++;
    end
    total++;
    if ({x7, x6, x5, x4, x3, x2, x1, x0} !== 32'h87654321 || wr_ptr !== 3'd0 || dones != 1) begin
      bad++;
      $display("FAIL basic_final got x=%h ptr=%0d dones=%0d want x=87654321 ptr=0 dones=1",
               {x7, x6, x5, x4, x3, x2, x1, x0}, wr_ptr, dones);
    end
  endtask

  task automatic test_partial_frame();
    logic [31:0] want;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 4'(9 + i), 1'b0, 1'b0);
      exp_s = sb.pop_front(); obs_s = get_obs(); total++;
      if (obs_s !== exp_s) begin bad++; $display("FAIL partial beat%0d got=%h want=%h", i, obs_s, exp_s); end
      if (i == 3) begin
`ifdef NIBBLE_DEMUX_DOUBLE_BUFFER_EN
        want = 32'h87654321;
`else
        want = 32'h8765CBA9;
`endif
        total++;
        if ({x7, x6, x5, x4, x3, x2, x1, x0} !== want) begin
          bad++; $display("FAIL partial_mid got=%h want=%h", {x7, x6, x5, x4, x3, x2, x1, x0}, want);
        end
      end
    end
    total++;
    if ({x7, x6, x5, x4, x3, x2, x1, x0} !== 32'h0FEDCBA9) begin
      bad++; $display("FAIL partial_end got=%h want=0fedcba9", {x7, x6, x5, x4, x3, x2, x1, x0});
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 14; i++) begin
      if (i < 8)       cycle(1'b1, 4'(i + 3), i == 0, i == 7);
      else if (i < 13) cycle(1'b1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b1);
      else             cycle(1'b0, 4'h0, 1'b0, 1'b0);
      exp_s = sb.pop_front(); obs_s = get_obs(); total++;
      if (obs_s !== exp_s) begin bad++; $display("FAIL hold step%0d got=%h want=%h", i, obs_s, exp_s); end
`ifdef NIBBLE_DEMUX_DOUBLE_BUFFER_EN
      if (i == 12) begin
        total++;
        if (in_ready !== 1'b0 || frame_done !== 1'b0) begin
          bad++; $display("FAIL hold_pend got rdy=%b done=%b want rdy=0 done=0", in_ready, frame_done);
        end
      end
`endif
    end
    cycle(1'b0, 4'h0, 1'b0, 1'b0);
    exp_s = sb.pop_front(); obs_s = get_obs(); total++;
    if (obs_s !== exp_s || in_ready !== 1'b1) begin
      bad++; $display("FAIL hold_release got=%h want=%h", obs_s, exp_s);
    end
  endtask

  task automatic test_abort();
    for (int i = 0; i < 11; i++) begin
      if (i < 3)       cycle(1'b1, 4'(i + 1), i == 0, 1'b0);
      else if (i == 3) cycle(1'b1, 4'hF, 1'b1, 1'b0);
      else             cycle(1'b1, 4'(i - 3), 1'b0, 1'b0);
      exp_s = sb.pop_front(); obs_s = get_obs(); total++;
      if (obs_s !== exp_s) begin bad++; $display("FAIL abort step%0d got=%h want=%h", i, obs_s, exp_s); end
      if (i == 3) begin
        total++;
        if (frame_abort !== 1'b1 || wr_ptr !== 3'd1) begin
          bad++; $display("FAIL abort_pulse got abort=%b ptr=%0d want abort=1 ptr=1", frame_abort, wr_ptr);
        end
      end
    end
    total++;
    if ({x7, x6, x5, x4, x3, x2, x1, x0} !== 32'h7654321F) begin
      bad++; $display("FAIL abort_frame got=%h want=7654321f", {x7, x6, x5, x4, x3, x2, x1, x0});
    end
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    for (int i = 0; i < 24; i++) begin
      cycle(1'b1, 4'($urandom_range(0, 15)), (i % 8) == 0, 1'b0);
      exp_s = sb.pop_front(); obs_s = get_obs(); total++;
      if (obs_s !== exp_s) begin bad++; $display("FAIL b2b beat%0d got=%h want=%h", i, obs_s, exp_s); end
      if (frame_done === 1'b1) dones++;
    end
    total++;
    if (dones != 3) begin bad++; $display("FAIL b2b_dones got=%0d want=3", dones); end
  endtask

  task automatic test_async_reset();
    for (int sc = 0; sc < 2; sc++) begin
      for (int i = 0; i < (sc == 0 ? 3 : 8); i++) begin
        cycle(1'b1, 4'(i + 5), i == 0, 1'b1);
        exp_s = sb.pop_front(); obs_s = get_obs(); total++;
        if (obs_s !== exp_s) begin bad++; $display("FAIL arst%0d fill%0d got=%h want=%h", sc, i, obs_s, exp_s); end
      end
      #2 reset_n = 1'b0;
      #1 model_reset();
      exp_s = sb.pop_front(); obs_s = get_obs(); total++;
      if (obs_s !== exp_s) begin bad++; $display("FAIL arst%0d during got=%h want=%h", sc, obs_s, exp_s); end
      @(negedge clk);
      reset_n = 1'b1;
      cycle(1'b0, 4'h0, 1'b0, 1'b0);
      exp_s = sb.pop_front(); obs_s = get_obs(); total++;
      if (obs_s !== exp_s || in_ready !== 1'b1) begin
        bad++; $display("FAIL arst%0d after got=%h want=%h", sc, obs_s, exp_s);
      end
    end
  endtask

`ifndef NIBBLE_DEMUX_DOUBLE_BUFFER_EN
  task automatic test_direct_hold();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, (i == 2) ? 4'h5 : 4'(i + 10), i == 0, 1'b1);
      exp_s = sb.pop_front(); obs_s = get_obs(); total++;
      if (obs_s !== exp_s) begin bad++; $display("FAIL direct beat%0d got=%h want=%h", i, obs_s, exp_s); end
    end
    total++;
    if (x2 !== 4'h5 || in_ready !== 1'b1 || wr_ptr !== 3'd3) begin
      bad++; $display("FAIL direct_x2 got x2=%h rdy=%b ptr=%0d want x2=5 rdy=1 ptr=3", x2, in_ready, wr_ptr);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_frame();
    test_partial_frame();
    test_hold();
    test_abort();
    test_back_to_back();
    test_async_reset();
`ifndef NIBBLE_DEMUX_DOUBLE_BUFFER_EN
    test_direct_hold();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
